// File: rtl/tt_vpu_ovi_pkg.sv
// Shared types for the OVI issue controller: sb_id, per-id status, issue payload
// and completion record.
package tt_vpu_ovi_pkg;

    localparam int OVI_NUM_SBID = 32;
    localparam int OVI_SBID_W   = $clog2(OVI_NUM_SBID);

    typedef logic [OVI_SBID_W-1:0] sb_id_t;

    typedef enum logic [1:0] {
        SBID_FREE   = 2'd0,
        SBID_ISSUED = 2'd1,
        SBID_SENIOR = 2'd2
    } sbid_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] scalar_opnd;
        logic [39:0] vcsr;
        logic        lmulb2;
    } issue_payload_t;

    typedef struct packed {
        sb_id_t      sb_id;
        logic [4:0]  fflags;
        logic [63:0] dest_reg;
        logic        vxsat;
        logic [13:0] vstart;
        logic        illegal;
    } completion_t;

endpackage

// File: rtl/tt_vpu_ovi_issue_ctrl_sbid_alloc.sv
// sb_id status array with lowest-free allocation and alloc/commit/complete updates.
// The three update ports always target distinct ids since each requires a different current status.
module tt_vpu_ovi_sbid_alloc
    import tt_vpu_ovi_pkg::*;
#(
    parameter int NUM_SBID = OVI_NUM_SBID
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   alloc_en,
    output logic   any_free,
    output sb_id_t free_sb_id,
    input  logic   cmt_en,
    input  logic   cmt_kill,
    input  sb_id_t cmt_sb_id,
    input  logic   cmpl_en,
    input  sb_id_t cmpl_sb_id,
    output logic   cmpl_legal
);

    sbid_state_e status_q [NUM_SBID];
    sbid_state_e status_d [NUM_SBID];

    // Scan from the top so the last hit is the lowest free index.
    always_comb begin
        any_free   = 1'b0;
        free_sb_id = '0;
        for (int i = NUM_SBID - 1; i >= 0; i--) begin
            if (status_q[i] == SBID_FREE) begin
                any_free   = 1'b1;
                free_sb_id = sb_id_t'(i);
            end
        end
    end

    assign cmpl_legal = cmpl_en && (status_q[cmpl_sb_id] == SBID_SENIOR);

    always_comb begin
        for (int i = 0; i < NUM_SBID; i++) begin
            status_d[i] = status_q[i];
        end
        if (alloc_en) begin
            status_d[free_sb_id] = SBID_ISSUED;
        end
        if (cmt_en) begin
            status_d[cmt_sb_id] = cmt_kill ? SBID_FREE : SBID_SENIOR;
        end
        if (cmpl_legal) begin
            status_d[cmpl_sb_id] = SBID_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SBID; i++) begin
                status_q[i] <= SBID_FREE;
            end
        end else begin
            for (int i = 0; i < NUM_SBID; i++) begin
                status_q[i] <= status_d[i];
            end
        end
    end

endmodule

// File: rtl/tt_vpu_ovi_issue_ctrl.sv
// OVI core-side issue controller: credits, in-order dispatch FIFO, issue/dispatch/resp registers.
// TT_VPU_OVI_ISSUE_CHECK_EN adds the sticky proto_err output and its checks.
module tt_vpu_ovi_issue_ctrl
    import tt_vpu_ovi_pkg::*;
#(
    parameter int CREDITS  = 4,
    parameter int NUM_SBID = OVI_NUM_SBID
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_inst,
    input  logic [63:0]           req_scalar_opnd,
    input  logic [39:0]           req_vcsr,
    input  logic                  req_vcsr_lmulb2,
    output logic [OVI_SBID_W-1:0] req_sb_id,
    input  logic                  cmt_valid,
    output logic                  cmt_ready,
    input  logic                  cmt_kill,
    output logic                  issue_valid,
    output logic [31:0]           issue_inst,
    output logic [OVI_SBID_W-1:0] issue_sb_id,
    output logic [63:0]           issue_scalar_opnd,
    output logic [39:0]           issue_vcsr,
    output logic                  issue_vcsr_lmulb2,
    input  logic                  issue_credit,
    output logic [OVI_SBID_W-1:0] dispatch_sb_id,
    output logic                  dispatch_next_senior,
    output logic                  dispatch_kill,
    input  logic                  completed_valid,
    input  logic [OVI_SBID_W-1:0] completed_sb_id,
    input  logic [4:0]            completed_fflags,
    input  logic [63:0]           completed_dest_reg,
    input  logic                  completed_vxsat,
    input  logic [13:0]           completed_vstart,
    input  logic                  completed_illegal,
    output logic                  resp_valid,
    output logic [OVI_SBID_W-1:0] resp_sb_id,
    output logic [4:0]            resp_fflags,
    output logic [63:0]           resp_dest_reg,
    output logic                  resp_vxsat,
    output logic [13:0]           resp_vstart,
    output logic                  resp_illegal
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
    ,
    output logic                  proto_err
`endif
);

    localparam int                CRED_W   = $clog2(CREDITS + 1);
    localparam int                PTR_W    = $clog2(NUM_SBID);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    logic [CRED_W-1:0] credits_q, credits_d;
    sb_id_t            fifo_q [NUM_SBID];
    sb_id_t            fifo_d [NUM_SBID];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              issue_valid_q, issue_valid_d;
    issue_payload_t    issue_pl_q, issue_pl_d;
    sb_id_t            issue_sb_id_q, issue_sb_id_d;
    sb_id_t            disp_sb_id_q, disp_sb_id_d;
    logic              disp_senior_q, disp_senior_d;
    logic              disp_kill_q, disp_kill_d;
    logic              resp_valid_q, resp_valid_d;
    completion_t       resp_q, resp_d;

    logic              any_free, accept, cmt_fire, cmpl_legal;
    sb_id_t            free_sb_id, head_sb_id;
    issue_payload_t    req_pl;
    completion_t       cmpl_in;

    tt_vpu_ovi_sbid_alloc #(.NUM_SBID(NUM_SBID)) u_sbid_alloc (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (accept),
        .any_free   (any_free),
        .free_sb_id (free_sb_id),
        .cmt_en     (cmt_fire),
        .cmt_kill   (cmt_kill),
        .cmt_sb_id  (head_sb_id),
        .cmpl_en    (completed_valid),
        .cmpl_sb_id (completed_sb_id),
        .cmpl_legal (cmpl_legal)
    );

    assign req_ready  = !reset && (credits_q != '0) && any_free;
    assign req_sb_id  = free_sb_id;
    assign accept     = req_valid && req_ready;
    assign cmt_ready  = !reset && (count_q != '0);
    assign cmt_fire   = cmt_valid && cmt_ready;
    assign head_sb_id = fifo_q[rd_ptr_q];

    always_comb begin
        req_pl             = '0;
        req_pl.inst        = req_inst;
        req_pl.scalar_opnd = req_scalar_opnd;
        req_pl.vcsr        = req_vcsr;
        req_pl.lmulb2      = req_vcsr_lmulb2;
        cmpl_in            = '0;
        cmpl_in.sb_id      = completed_sb_id;
        cmpl_in.fflags     = completed_fflags;
        cmpl_in.dest_reg   = completed_dest_reg;
        cmpl_in.vxsat      = completed_vxsat;
        cmpl_in.vstart     = completed_vstart;
        cmpl_in.illegal    = completed_illegal;
    end

    always_comb begin
        // A returned credit on a full counter saturates rather than wrapping.
        credits_d = credits_q;
        if (accept && !issue_credit) begin
            credits_d = credits_q - 1'b1;
        end else if (!accept && issue_credit && credits_q != CRED_MAX) begin
            credits_d = credits_q + 1'b1;
        end

        for (int i = 0; i < NUM_SBID; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            fifo_d[wr_ptr_q] = free_sb_id;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (cmt_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (accept && !cmt_fire) begin
            count_d = count_q + 1'b1;
        end else if (!accept && cmt_fire) begin
            count_d = count_q - 1'b1;
        end

        issue_valid_d = accept;
        issue_pl_d    = accept ? req_pl : issue_pl_q;
        issue_sb_id_d = accept ? free_sb_id : issue_sb_id_q;
        disp_senior_d = cmt_fire && !cmt_kill;
        disp_kill_d   = cmt_fire && cmt_kill;
        disp_sb_id_d  = cmt_fire ? head_sb_id : disp_sb_id_q;
        resp_valid_d  = cmpl_legal;
        resp_d        = cmpl_legal ? cmpl_in : resp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q     <= CRED_MAX;
            for (int i = 0; i < NUM_SBID; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_pl_q    <= '0;
            issue_sb_id_q <= '0;
            disp_sb_id_q  <= '0;
            disp_senior_q <= 1'b0;
            disp_kill_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_q        <= '0;
        end else begin
            credits_q     <= credits_d;
            for (int i = 0; i < NUM_SBID; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_pl_q    <= issue_pl_d;
            issue_sb_id_q <= issue_sb_id_d;
            disp_sb_id_q  <= disp_sb_id_d;
            disp_senior_q <= disp_senior_d;
            disp_kill_q   <= disp_kill_d;
            resp_valid_q  <= resp_valid_d;
            resp_q        <= resp_d;
        end
    end

    assign issue_valid          = issue_valid_q;
    assign issue_inst           = issue_pl_q.inst;
    assign issue_sb_id          = issue_sb_id_q;
    assign issue_scalar_opnd    = issue_pl_q.scalar_opnd;
    assign issue_vcsr           = issue_pl_q.vcsr;
    assign issue_vcsr_lmulb2    = issue_pl_q.lmulb2;
    assign dispatch_sb_id       = disp_sb_id_q;
    assign dispatch_next_senior = disp_senior_q;
    assign dispatch_kill        = disp_kill_q;
    assign resp_valid           = resp_valid_q;
    assign resp_sb_id           = resp_q.sb_id;
    assign resp_fflags          = resp_q.fflags;
    assign resp_dest_reg        = resp_q.dest_reg;
    assign resp_vxsat           = resp_q.vxsat;
    assign resp_vstart          = resp_q.vstart;
    assign resp_illegal         = resp_q.illegal;

`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
    logic       proto_err_q, proto_err_d;
    logic [9:0] wd_cnt_q, wd_cnt_d;
    logic       wd_expire;

    // Watchdog counts prior consecutive stalled-commit cycles; the 1024th trips it.
    always_comb begin
        wd_cnt_d  = '0;
        wd_expire = 1'b0;
        if (cmt_valid && count_q == '0) begin
            wd_expire = (wd_cnt_q == 10'h3ff);
            wd_cnt_d  = wd_expire ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        proto_err_d = proto_err_q
                    | (completed_valid && !cmpl_legal)
                    | (issue_credit && credits_q == CRED_MAX)
                    | wd_expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_tt_vpu_ovi_issue_ctrl.sv
// Directed bench for tt_vpu_ovi_issue_ctrl with a queue/array reference model and per-cycle compare.
module tb_tt_vpu_ovi_issue_ctrl;

    localparam int CREDITS = 4;
    localparam int NSB     = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_inst;
    logic [63:0] req_scalar_opnd;
    logic [39:0] req_vcsr;
    logic        req_vcsr_lmulb2;
    logic [4:0]  req_sb_id;
    logic        cmt_valid, cmt_ready, cmt_kill;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [4:0]  issue_sb_id;
    logic [63:0] issue_scalar_opnd;
    logic [39:0] issue_vcsr;
    logic        issue_vcsr_lmulb2;
    logic        issue_credit;
    logic [4:0]  dispatch_sb_id;
    logic        dispatch_next_senior, dispatch_kill;
    logic        completed_valid;
    logic [4:0]  completed_sb_id;
    logic [4:0]  completed_fflags;
    logic [63:0] completed_dest_reg;
    logic        completed_vxsat;
    logic [13:0] completed_vstart;
    logic        completed_illegal;
    logic        resp_valid;
    logic [4:0]  resp_sb_id;
    logic [4:0]  resp_fflags;
    logic [63:0] resp_dest_reg;
    logic        resp_vxsat;
    logic [13:0] resp_vstart;
    logic        resp_illegal;
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
    logic        proto_err;
`endif

    always #5 clk = ~clk;

    tt_vpu_ovi_issue_ctrl #(.CREDITS(CREDITS), .NUM_SBID(NSB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
        .req_scalar_opnd(req_scalar_opnd), .req_vcsr(req_vcsr),
        .req_vcsr_lmulb2(req_vcsr_lmulb2), .req_sb_id(req_sb_id),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_kill(cmt_kill),
        .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_sb_id(issue_sb_id),
        .issue_scalar_opnd(issue_scalar_opnd), .issue_vcsr(issue_vcsr),
        .issue_vcsr_lmulb2(issue_vcsr_lmulb2), .issue_credit(issue_credit),
        .dispatch_sb_id(dispatch_sb_id), .dispatch_next_senior(dispatch_next_senior),
        .dispatch_kill(dispatch_kill),
        .completed_valid(completed_valid), .completed_sb_id(completed_sb_id),
        .completed_fflags(completed_fflags), .completed_dest_reg(completed_dest_reg),
        .completed_vxsat(completed_vxsat), .completed_vstart(completed_vstart),
        .completed_illegal(completed_illegal),
        .resp_valid(resp_valid), .resp_sb_id(resp_sb_id), .resp_fflags(resp_fflags),
        .resp_dest_reg(resp_dest_reg), .resp_vxsat(resp_vxsat), .resp_vstart(resp_vstart),
        .resp_illegal(resp_illegal)
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
        , .proto_err(proto_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=free 1=awaiting commit 2=awaiting completion
    int          st [NSB];
    int          cred;
    int          q [$];
    int          wd;
    bit          m_perr;
    bit          m_iv, m_dns, m_dk, m_rv;
    logic [31:0] m_inst;
    logic [63:0] m_opnd, m_rdest;
    logic [39:0] m_vcsr;
    logic        m_lmul, m_rvx, m_ril;
    int          m_isb, m_dsb, m_rsb;
    logic [4:0]  m_rff;
    logic [13:0] m_rvs;
    int          lf, hd;
    bit          acc, fire, legal;

    function automatic int lowest_free();
        for (int i = 0; i < NSB; i++) if (st[i] == 0) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSB; i++) st[i] = 0;
            q.delete();
            cred = CREDITS; wd = 0; m_perr = 0;
            m_iv = 0; m_dns = 0; m_dk = 0; m_rv = 0;
        end else begin
            lf    = lowest_free();
            acc   = req_valid && cred != 0 && lf >= 0;
            fire  = cmt_valid && q.size() != 0;
            legal = completed_valid && st[completed_sb_id] == 2;
            if (completed_valid && !legal) m_perr = 1;
            if (issue_credit && cred == CREDITS) m_perr = 1;
            if (cmt_valid && q.size() == 0) begin
                wd++;
                if (wd >= 1024) m_perr = 1;
            end else begin
                wd = 0;
            end
            m_iv = acc;
            if (acc) begin
                m_inst = req_inst; m_opnd = req_scalar_opnd; m_vcsr = req_vcsr;
                m_lmul = req_vcsr_lmulb2; m_isb = lf;
            end
            m_dns = 0; m_dk = 0;
            if (fire) begin
                hd = q.pop_front();
                m_dsb = hd;
                if (cmt_kill) begin m_dk = 1; st[hd] = 0; end
                else begin m_dns = 1; st[hd] = 2; end
            end
            m_rv = legal;
            if (legal) begin
                m_rsb = completed_sb_id; m_rff = completed_fflags; m_rdest = completed_dest_reg;
                m_rvx = completed_vxsat; m_rvs = completed_vstart; m_ril = completed_illegal;
                st[completed_sb_id] = 0;
            end
            if (acc) begin
                st[lf] = 1;
                q.push_back(lf);
            end
            cred = cred - int'(acc) + int'(issue_credit);
            if (cred > CREDITS) cred = CREDITS;
        end
    end

    bit e_rdy;
    always @(negedge clk) begin
        #2;
        e_rdy = !reset && cred != 0 && lowest_free() >= 0;
        check("req_ready", req_ready, e_rdy);
        if (req_valid && e_rdy) check("req_sb_id", req_sb_id, lowest_free());
        check("cmt_ready", cmt_ready, !reset && q.size() != 0);
        check("issue_valid", issue_valid, m_iv);
        if (m_iv) begin
            check("issue_sb_id", issue_sb_id, m_isb);
            check("issue_inst", issue_inst, m_inst);
            check("issue_opnd", issue_scalar_opnd, m_opnd);
            check("issue_vcsr", issue_vcsr, m_vcsr);
            check("issue_lmulb2", issue_vcsr_lmulb2, m_lmul);
        end
        check("disp_senior", dispatch_next_senior, m_dns);
        check("disp_kill", dispatch_kill, m_dk);
        if (m_dns || m_dk) check("disp_sb_id", dispatch_sb_id, m_dsb);
        check("resp_valid", resp_valid, m_rv);
        if (m_rv) begin
            check("resp_sb_id", resp_sb_id, m_rsb);
            check("resp_fflags", resp_fflags, m_rff);
            check("resp_dest", resp_dest_reg, m_rdest);
            check("resp_vxsat", resp_vxsat, m_rvx);
            check("resp_vstart", resp_vstart, m_rvs);
            check("resp_illegal", resp_illegal, m_ril);
        end
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
        check("proto_err", proto_err, m_perr);
`endif
    end

    task automatic idle();
        req_valid = 0; cmt_valid = 0; cmt_kill = 0; issue_credit = 0; completed_valid = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic req(input int n);
        req_valid       = 1;
        req_inst        = 32'hA000_0000 | 32'(n);
        req_scalar_opnd = {32'hC0DE_0000, 32'(n)};
        req_vcsr        = 40'h12_0000_0000 + 40'(n);
        req_vcsr_lmulb2 = n[0];
    endtask

    task automatic cmpl(input int id);
        completed_valid    = 1;
        completed_sb_id    = 5'(id);
        completed_fflags   = 5'(id + 1);
        completed_dest_reg = 64'hD000_0000_0000_0000 + 64'(id);
        completed_vxsat    = id[0];
        completed_vstart   = 14'(id * 3);
        completed_illegal  = id[1];
    endtask

    task automatic do_reset();
        tick(); reset = 1; #2;
        tick(); reset = 1; #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_cmt_ready", cmt_ready, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_sb_id", issue_sb_id, 0);
        check("rst_issue_inst", issue_inst, 0);
        check("rst_disp", {dispatch_next_senior, dispatch_kill, dispatch_sb_id}, 0);
        check("rst_resp", {resp_valid, resp_sb_id, resp_dest_reg}, 0);
        check("rst_credits", dut.credits_q, CREDITS);
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
        check("rst_proto_err", proto_err, 0);
`endif
        tick(); reset = 0; #2;
    endtask

    initial begin
        reset = 1; idle();
        req_inst = 0; req_scalar_opnd = 0; req_vcsr = 0; req_vcsr_lmulb2 = 0;
        completed_sb_id = 0; completed_fflags = 0; completed_dest_reg = 0;
        completed_vxsat = 0; completed_vstart = 0; completed_illegal = 0;

        // 4 credits: ids 0..3, then stall, then one credit lets id 4 through
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(); req(k); #2;
            check("t1_ready", req_ready, 1);
            check("t1_sb_id", req_sb_id, k);
        end
        tick(); req(4); #2;
        check("t1_stall", req_ready, 0);
        check("t1_issue_sb3", issue_sb_id, 3);
        tick(); req(4); issue_credit = 1; #2;
        check("t1_stall2", req_ready, 0);
        tick(); req(4); #2;
        check("t1_ready5", req_ready, 1);
        check("t1_sb_id5", req_sb_id, 4);
        tick(); #2;
        check("t1_issue5", {issue_valid, issue_sb_id}, {1'b1, 5'd4});
        check("t1_inst5", issue_inst, 32'hA000_0004);

        // senior then kill; killed id is reused
        do_reset();
        tick(); req(10); #2; check("t2_sb0", req_sb_id, 0);
        tick(); req(11); #2; check("t2_sb1", req_sb_id, 1); check("t2_cmt_rdy", cmt_ready, 1);
        tick(); cmt_valid = 1; cmt_kill = 0; #2;
        tick(); cmt_valid = 1; cmt_kill = 1; #2;
        check("t2_senior", {dispatch_next_senior, dispatch_kill, dispatch_sb_id}, {2'b10, 5'd0});
        tick(); req(12); #2;
        check("t2_kill", {dispatch_next_senior, dispatch_kill, dispatch_sb_id}, {2'b01, 5'd1});
        check("t2_reuse", req_sb_id, 1);

        // fill all 32 ids, all senior, then complete 17 and reallocate it
        do_reset();
        for (int i = 0; i < NSB; i++) begin
            tick(); req(100 + i); issue_credit = (i != 0); #2;
            check("t3_fill_sb", req_sb_id, i);
        end
        for (int i = 0; i < NSB; i++) begin
            tick(); cmt_valid = 1; #2;
        end
        tick(); #2;
        check("t3_last_disp", {dispatch_next_senior, dispatch_sb_id}, {1'b1, 5'd31});
        tick(); req(200); cmpl(17); #2;
        check("t3_full", req_ready, 0);
        tick(); req(200); #2;
        check("t3_resp", {resp_valid, resp_sb_id}, {1'b1, 5'd17});
        check("t3_resp_dest", resp_dest_reg, 64'hD000_0000_0000_0011);
        check("t3_realloc", {req_ready, req_sb_id}, {1'b1, 5'd17});

        // accept + credit + completion together
        tick(); cmpl(5); #2;
        tick(); req(300); issue_credit = 1; cmpl(6); #2;
        check("t4_sb", req_sb_id, 5);
        tick(); #2;
        check("t4_credits", dut.credits_q, 2);
        check("t4_resp", {resp_valid, resp_sb_id}, {1'b1, 5'd6});
        check("t4_issue", {issue_valid, issue_sb_id}, {1'b1, 5'd5});
        check("t4_distinct", issue_sb_id != resp_sb_id, 1);

        // completion of a FREE id
        do_reset();
        tick(); cmpl(9); #2;
        tick(); req(500); #2;
        check("t5_no_resp", resp_valid, 0);
        check("t5_sb0", req_sb_id, 0);
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
        check("t5_perr", proto_err, 1);
        repeat (3) begin tick(); #2; end
        check("t5_perr_held", proto_err, 1);
`endif

        // credit saturation, then reset with 3 outstanding
        do_reset();
        tick(); issue_credit = 1; #2;
        tick(); #2;
        check("t6_sat", dut.credits_q, CREDITS);
        for (int k = 0; k < 3; k++) begin
            tick(); req(400 + k); #2;
        end
        tick(); reset = 1; req(403); cmt_valid = 1; cmpl(0); #2;
        tick(); reset = 0; #2;
        check("t6_issue", {issue_valid, issue_sb_id, issue_inst}, 0);
        check("t6_disp", {dispatch_next_senior, dispatch_kill, dispatch_sb_id}, 0);
        check("t6_resp", {resp_valid, resp_sb_id}, 0);
        check("t6_cmt_rdy", cmt_ready, 0);
        check("t6_credits", dut.credits_q, CREDITS);
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
        check("t6_perr", proto_err, 0);
`endif

        // commit watchdog on an empty FIFO
        do_reset();
        repeat (1023) begin tick(); cmt_valid = 1; #2; end
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
        check("t7_wd_early", proto_err, 0);
`endif
        tick(); cmt_valid = 1; #2;
        tick(); #2;
`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
        check("t7_wd", proto_err, 1);
`endif
        check("t7_cmt_rdy", cmt_ready, 0);

        tick(); #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tt_vpu_ovi_issue_ctrl.md
# tt_vpu_ovi_issue_ctrl

Core-side initiator for the Open Vector Interface (OVI). It accepts vector instructions from the scalar core and allocates a free scoreboard id (sb_id) for each one. It drives the OVI issue bus under VPU credit control, sequences in-order dispatch.next_senior and dispatch.kill, and retires sb_ids on completion or kill. It sits between the core's vector issue/commit stage and tt_vpu_ovi, and is the master that keeps the OVI protocol legal.

## Interface
- CREDITS, default 4: initial issue credits granted by the VPU after reset.
- NUM_SBID, default 32: number of sb_ids; sb_id width is $clog2(NUM_SBID) = 5.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req_valid / req_ready  in/out  1  core instruction handshake.
- req_inst  in  32  instruction; req_scalar_opnd  in  64; req_vcsr  in  40; req_vcsr_lmulb2  in  1.
- req_sb_id  out  5  sb_id allocated for the request; valid while req_valid && req_ready.
- cmt_valid / cmt_ready  in/out  1  in-order commit decision for the oldest undispatched instruction; cmt_kill  in  1  (1 = kill, 0 = senior).
- issue_valid  out  1; issue_inst  out  32; issue_sb_id  out  5; issue_scalar_opnd  out  64; issue_vcsr  out  40; issue_vcsr_lmulb2  out  1.
- issue_credit  in  1  one credit returned per cycle high.
- dispatch_sb_id  out  5; dispatch_next_senior  out  1; dispatch_kill  out  1.
- completed_valid  in  1; completed_sb_id  in  5; completed_fflags  in  5; completed_dest_reg  in  64; completed_vxsat  in  1; completed_vstart  in  14; completed_illegal  in  1.
- resp_valid  out  1; resp_sb_id  out  5; resp_fflags, resp_dest_reg, resp_vxsat, resp_vstart, resp_illegal: same widths as the completed_* inputs, registered copies.
- proto_err  out  1  sticky protocol error; present only when the configuration macro is defined.

## Operation
- State per sb_id is a 2-bit status: FREE, ISSUED (awaiting commit), SENIOR (awaiting completion).
- Credit counter: width $clog2(CREDITS+1); reset to CREDITS. Decrements on accept and increments on issue_credit. Accept and credit in the same cycle gives a net of 0.
- req_ready = (credits != 0) && (any sb_id FREE). The dispatch FIFO has NUM_SBID entries and can never be full.
- On accept:
  - The lowest-index FREE sb_id goes ISSUED.
  - The sb_id is pushed into the in-order dispatch FIFO.
  - The payload and sb_id are registered onto the issue bus.
- cmt_ready = dispatch FIFO non-empty. On a cmt handshake, the head is popped and registered onto the dispatch bus.
  - cmt_kill=0: the sb_id goes SENIOR.
  - cmt_kill=1: the sb_id goes FREE.
- completed_valid for a SENIOR sb_id sets it FREE and forwards the completion to resp_*. There is no backpressure.
- next_senior and kill are mutually exclusive by construction.
- A completing sb_id is never the issuing sb_id, because allocation only picks FREE ids.

## Timing
- Reset values: every output is 0. All sb_ids FREE, FIFO empty, credits = CREDITS.
- Accept in cycle N: issue_valid is high for exactly cycle N+1.
- Commit in cycle N: dispatch_next_senior or dispatch_kill is high for exactly cycle N+1, with dispatch_sb_id.
- issue_sb_id and dispatch_sb_id may be equal in the same cycle. Earliest case: accept N, commit N+1, both visible on N+2 vs N+1 buses as registered.
- completed_valid in cycle N: resp_valid is high in cycle N+1.
  - The freed sb_id is allocatable from cycle N+1.
  - Same for a kill: the id is freed at commit N and allocatable from N+1.
- Allocation reads registered status only. No same-cycle bypass of a freed id.
- Reset asserted mid-operation: everything returns to reset values next cycle. In-flight instructions are discarded and no dispatch or resp pulse is produced.

## Configuration
- TT_VPU_OVI_ISSUE_CHECK_EN defined: proto_err is present. It is set, and held until reset, on any of:
  - completion of a non-SENIOR sb_id;
  - issue_credit while credits == CREDITS;
  - cmt_valid with an empty FIFO that lasts 1024 consecutive cycles (commit watchdog).
- Undefined: the proto_err port and its logic are absent. An illegal completion is ignored, with no state change and no resp. Credit overflow saturates at CREDITS.

## Structure
- Package tt_vpu_ovi_pkg holds:
  - sb_id_t;
  - the sbid_state_e enum (FREE/ISSUED/SENIOR);
  - the issue payload struct (inst, scalar_opnd, vcsr, lmulb2);
  - the completion struct;
  - OVI_NUM_SBID.
- Sub-module tt_vpu_ovi_sbid_alloc holds the status array, the lowest-free priority encoder, and the alloc/commit/complete update ports. The top level holds the credit counter, dispatch FIFO and output registers.

## Test plan
- Reset, then 5 back-to-back requests with no credit return:
  - 4 accepted with sb_ids 0,1,2,3;
  - req_ready=0 on the 5th;
  - one issue_credit pulse means the 5th is accepted with sb_id 4.
- Issue sb_ids 0,1. Commit senior, then kill:
  - dispatch_next_senior with sb_id 0, then dispatch_kill with sb_id 1;
  - next request reuses sb_id 1.
- Fill all 32 sb_ids (credits refilled every cycle), all senior:
  - req_ready=0;
  - completed_valid sb_id 17 means resp_valid the next cycle with sb_id 17, and the next accept gets sb_id 17.
- Accept, issue_credit and completion in the same cycle:
  - credits unchanged;
  - completion forwarded;
  - the new id differs from the completing id.
- With TT_VPU_OVI_ISSUE_CHECK_EN: completion of FREE sb_id 9 sets proto_err the next cycle, held until reset. Without it: no resp, no state change.
- Assert reset with 3 instructions outstanding: all outputs are 0 next cycle and credits return to 4.
